// File: rtl/status_bank_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | status_bank_arbiter_if: request/status bus of the status bank      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface status_bank_arbiter_if #(
  parameter int N = 10,
  parameter int W = 4
);
  logic           init;
  logic           hold;
  logic [2:0]     active_cnt;
  logic [N-1:0]   req;
  logic [N*W-1:0] status;
  logic [N-1:0]   pend;
  logic           grant_vld;
  logic [3:0]     grant_idx;
  logic           wrap_evt;
  logic [3:0]     wrap_idx;

  modport master (
    output init, hold, active_cnt, req,
    input  status, pend, grant_vld, grant_idx, wrap_evt, wrap_idx
  );

  modport slave (
    input  init, hold, active_cnt, req,
    output status, pend, grant_vld, grant_idx, wrap_evt, wrap_idx
  );
endinterface
`default_nettype wire

// File: rtl/status_bank_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | status_bank_arbiter: round-robin increment arbiter over status bank|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module status_bank_arbiter #(
  parameter int N        = 10,
  parameter int W        = 4,
  parameter int MAXV     = 9,
  parameter int INIT_VAL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  status_bank_arbiter_if.slave bus
);
  localparam logic [3:0] c_PTR_RST = 4'(N - 1);

  logic [W-1:0] field_q [N];
  logic [N-1:0] req_q;
  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;
  logic [3:0]   ptr_q;
  logic         grant_vld_q;
  logic [3:0]   grant_idx_q;
  logic         wrap_evt_q;
  logic [3:0]   wrap_idx_q;

  logic [4:0]   w_act_num;
  logic [N-1:0] w_mask;
  logic [N-1:0] w_rise;
  logic [N-1:0] w_pend_m;
  logic [N-1:0] w_onehot;
  logic [4:0]   w_idx;
  logic         w_found;
  logic [3:0]   w_sel;
  logic [W-1:0] w_fld_cur;
  logic         w_wrap;
  logic [W-1:0] w_fld_nxt;

  // Active object count: 2*active_cnt, saturating at N; codes 6 and 7 select all.
  always_comb begin
    w_act_num = 5'd0;
    if (bus.active_cnt >= 3'd6) begin
      w_act_num = 5'(N);
    end else if (5'({bus.active_cnt, 1'b0}) > 5'(N)) begin
      w_act_num = 5'(N);
    end else begin
      w_act_num = 5'({bus.active_cnt, 1'b0});
    end
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (5'(i) < w_act_num);
    end
  end

  assign w_rise   = bus.req & ~req_q & w_mask;
  assign w_pend_m = pend_q & w_mask;

  // Search starts just after the last granted index and wraps modulo N.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 4'd0;
    w_idx   = 5'd0;
    if (!bus.hold) begin
      for (int k = 1; k <= N; k++) begin
        w_idx = {1'b0, ptr_q} + 5'(k);
        if (w_idx >= 5'(N)) begin
          w_idx = w_idx - 5'(N);
        end
        if (!w_found && w_pend_m[w_idx[3:0]]) begin
          w_found = 1'b1;
          w_sel   = w_idx[3:0];
        end
      end
    end
  end

  assign w_onehot  = w_found ? ({{(N-1){1'b0}}, 1'b1} << w_sel) : '0;
  assign w_fld_cur = field_q[w_sel];
  assign w_wrap    = (w_fld_cur == W'(MAXV));
  assign w_fld_nxt = w_wrap ? '0 : w_fld_cur + 1'b1;
  assign pend_d    = ((pend_q & ~w_onehot) | w_rise) & w_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= '0;
      pend_q      <= '0;
      ptr_q       <= c_PTR_RST;
      grant_vld_q <= 1'b0;
      grant_idx_q <= 4'd0;
      wrap_evt_q  <= 1'b0;
      wrap_idx_q  <= 4'd0;
      for (int i = 0; i < N; i++) begin
        field_q[i] <= W'(INIT_VAL);
      end
    end else if (bus.init) begin
      req_q       <= bus.req;
      pend_q      <= '0;
      ptr_q       <= c_PTR_RST;
      grant_vld_q <= 1'b0;
      wrap_evt_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        field_q[i] <= W'(INIT_VAL);
      end
    end else begin
      req_q  <= bus.req;
      pend_q <= pend_d;
      if (w_found) begin
        field_q[w_sel] <= w_fld_nxt;
        ptr_q          <= w_sel;
        grant_vld_q    <= 1'b1;
        grant_idx_q    <= w_sel;
        wrap_evt_q     <= w_wrap;
        if (w_wrap) begin
          wrap_idx_q <= w_sel;
        end
      end else begin
        grant_vld_q <= 1'b0;
        wrap_evt_q  <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign bus.status[gi*W +: W] = field_q[gi];
    end
  endgenerate

  assign bus.pend      = pend_q;
  assign bus.grant_vld = grant_vld_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.wrap_evt  = wrap_evt_q;
  assign bus.wrap_idx  = wrap_idx_q;
endmodule
`default_nettype wire

// File: tb/tb_status_bank_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_status_bank_arbiter: directed + random bench with array model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_status_bank_arbiter;
  localparam int N        = 10;
  localparam int W        = 4;
  localparam int MAXV     = 9;
  localparam int INIT_VAL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  status_bank_arbiter_if #(.N(N), .W(W)) ifc ();

  status_bank_arbiter #(.N(N), .W(W), .MAXV(MAXV), .INIT_VAL(INIT_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference state: plain integers per object.
  int fld [N];
  bit pm  [N];
  bit rqp [N];
  int ptr;
  bit m_gv, m_we;
  int m_gi, m_wi;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model();
    int cnt;
    int sel;
    int j;
    int ac;
    bit rise [N];
    ac  = int'(ifc.active_cnt);
    cnt = (ac >= 6) ? N : ((2 * ac > N) ? N : 2 * ac);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        fld[i] = INIT_VAL; pm[i] = 0; rqp[i] = 0;
      end
      ptr = N - 1; m_gv = 0; m_we = 0; m_gi = 0; m_wi = 0;
    end else if (ifc.init) begin
      for (int i = 0; i < N; i++) begin
        fld[i] = INIT_VAL; pm[i] = 0; rqp[i] = ifc.req[i];
      end
      ptr = N - 1; m_gv = 0; m_we = 0;
    end else begin
      sel = -1;
      if (!ifc.hold) begin
        for (int k = 1; k <= N; k++) begin
          j = (ptr + k) % N;
          if (sel < 0 && pm[j] && j < cnt) sel = j;
        end
      end
      for (int i = 0; i < N; i++) rise[i] = ifc.req[i] && !rqp[i] && (i < cnt);
      if (sel >= 0) begin
        m_gv = 1; m_gi = sel; ptr = sel;
        if (fld[sel] == MAXV) begin
          fld[sel] = 0; m_we = 1; m_wi = sel;
        end else begin
          fld[sel] = fld[sel] + 1; m_we = 0;
        end
      end else begin
        m_gv = 0; m_we = 0;
      end
      for (int i = 0; i < N; i++) begin
        pm[i]  = ((pm[i] && i != sel) || rise[i]) && (i < cnt);
        rqp[i] = ifc.req[i];
      end
    end
  endtask

  task automatic step();
    logic [N*W-1:0] exp_st;
    logic [N-1:0]   exp_pd;
    model();
    @(posedge clk);
    #1;
    vectors++;
    for (int i = 0; i < N; i++) begin
      exp_st[i*W +: W] = W'(fld[i]);
      exp_pd[i]        = pm[i];
    end
    chk("status", 64'(ifc.status), 64'(exp_st));
    chk("pend", 64'(ifc.pend), 64'(exp_pd));
    chk("grant_vld", 64'(ifc.grant_vld), 64'(m_gv));
    chk("grant_idx", 64'(ifc.grant_idx), 64'(m_gi));
    chk("wrap_evt", 64'(ifc.wrap_evt), 64'(m_we));
    chk("wrap_idx", 64'(ifc.wrap_idx), 64'(m_wi));
  endtask

  initial begin
    logic [N*W-1:0] all_two;
    logic [N*W-1:0] all_one;
    for (int i = 0; i < N; i++) begin
      all_two[i*W +: W] = 4'd2;
      all_one[i*W +: W] = 4'd1;
    end
    ifc.init = 0; ifc.hold = 0; ifc.active_cnt = 3'd2; ifc.req = '0;

    // Reset state
    rst = 1; step(); step();
    chk("rst_status", 64'(ifc.status), 64'(all_one));
    chk("rst_pend", 64'(ifc.pend), 64'd0);
    chk("rst_gidx", 64'(ifc.grant_idx), 64'd0);

    // Single request on object 3
    rst = 0; step();
    ifc.req = 10'b00_0000_1000; step();
    chk("t1_pend", 64'(ifc.pend), 64'h8);
    chk("t1_gv0", 64'(ifc.grant_vld), 64'd0);
    step();
    chk("t1_field3", 64'(ifc.status[15:12]), 64'd2);
    chk("t1_gv", 64'(ifc.grant_vld), 64'd1);
    chk("t1_gidx", 64'(ifc.grant_idx), 64'd3);
    chk("t1_wrap", 64'(ifc.wrap_evt), 64'd0);

    // Drive field 0 to MAXV, then wrap it
    ifc.req = '0; step();
    for (int p = 0; p < 8; p++) begin
      ifc.req = 10'b1; step();
      ifc.req = '0;    step();
    end
    chk("t2_field0_max", 64'(ifc.status[3:0]), 64'd9);
    ifc.req = 10'b1; step();
    ifc.req = '0;    step();
    chk("t2_field0_wrap", 64'(ifc.status[3:0]), 64'd0);
    chk("t2_wrap_evt", 64'(ifc.wrap_evt), 64'd1);
    chk("t2_wrap_idx", 64'(ifc.wrap_idx), 64'd0);
    step();
    chk("t2_wrap_pulse", 64'(ifc.wrap_evt), 64'd0);

    // All ten request together: round-robin 0..9
    rst = 1; step();
    rst = 0; ifc.active_cnt = 3'd5; ifc.req = '1; step();
    for (int k = 0; k < N; k++) begin
      step();
      chk("t3_gv", 64'(ifc.grant_vld), 64'd1);
      chk("t3_gidx", 64'(ifc.grant_idx), 64'(k));
    end
    chk("t3_status", 64'(ifc.status), 64'(all_two));
    chk("t3_pend", 64'(ifc.pend), 64'd0);

    // Mask excludes object 5
    ifc.active_cnt = 3'd1; ifc.req = '0; step();
    ifc.req = 10'b00_0010_0010; step();
    chk("t4_pend", 64'(ifc.pend), 64'h2);
    step();
    chk("t4_gidx", 64'(ifc.grant_idx), 64'd1);
    chk("t4_field5", 64'(ifc.status[23:20]), 64'd2);

    // Hold accumulates, release serves in order
    ifc.req = '0; rst = 1; step();
    rst = 0; ifc.active_cnt = 3'd2; ifc.hold = 1; ifc.req = 10'b101; step();
    step();
    chk("t5_pend", 64'(ifc.pend), 64'h5);
    chk("t5_nogrant", 64'(ifc.grant_vld), 64'd0);
    ifc.hold = 0; step();
    chk("t5_g0", 64'(ifc.grant_idx), 64'd0);
    step();
    chk("t5_g2", 64'(ifc.grant_idx), 64'd2);

    // init and rst with requests queued
    ifc.active_cnt = 3'd5; ifc.req = '0; ifc.hold = 1; step();
    ifc.req = 10'b11; step();
    chk("t6_pend", 64'(ifc.pend), 64'h3);
    ifc.init = 1; step();
    chk("t6_init_status", 64'(ifc.status), 64'(all_one));
    chk("t6_init_pend", 64'(ifc.pend), 64'd0);
    chk("t6_init_gv", 64'(ifc.grant_vld), 64'd0);
    ifc.init = 0; ifc.req = '0; step();
    ifc.req = 10'b11; step();
    rst = 1; step();
    chk("t6_rst_pend", 64'(ifc.pend), 64'd0);
    chk("t6_rst_gidx", 64'(ifc.grant_idx), 64'd0);
    rst = 0; ifc.hold = 0;

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      ifc.req  = N'($urandom) & N'($urandom);
      ifc.hold = ($urandom_range(0, 9) == 0);
      ifc.init = ($urandom_range(0, 49) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) ifc.active_cnt = 3'($urandom_range(0, 7));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
